// File: rtl/pipe_drain_fifo.sv
// pipe_drain_fifo: credit-tracked receive buffer for a fixed-latency pipeline.
// Upstream may issue an op only while a credit is free. A free credit means
// stored words plus in-flight ops is below DEPTH. Arriving results are buffered
// in a first-word-fall-through FIFO and drained by a valid/ready consumer.
module pipe_drain_fifo #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PIPE_LAT   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue,
  output logic                       issue_ok,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     inflight,
  output logic                       err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(DEPTH);

  // The credit scheme does not depend on the pipeline latency. The latency
  // parameter is only sanity-checked here.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (PIPE_LAT == 0)) begin : g_bad_param
    $error("pipe_drain_fifo: DEPTH must be a power of 2 >= 2 and PIPE_LAT >= 1");
  end

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  full;
  logic                  push;
  logic                  pop;
  logic [CW:0]           credit_sum;

  // Status and handshake decode. These signals use registered state only,
  // except for push and pop, which also depend on their qualifying inputs.
  always_comb begin
    credit_sum = {1'b0, count_q} + {1'b0, inflight_q};
    issue_ok   = credit_sum < DEPTH_SUM;
    full       = (count_q == DEPTH_C);
    out_valid  = (count_q != '0);
    pop        = out_valid & out_ready;
    // When the FIFO is full, a pop in the same cycle frees the head slot.
    // The write then lands on the entry that is being read out.
    push       = in_valid & (~full | pop);
  end

  // Next-state computation for the pointers, the occupancy, the credits and the sticky error.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);

    count_d    = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    inflight_d = inflight_q;
    if (issue && !in_valid) begin
      if (inflight_q != DEPTH_C) inflight_d = inflight_q + 1'b1;
    end else if (in_valid && !issue) begin
      if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
    end

    err_d = err_q
          | (issue & ~issue_ok)
          | (in_valid & (inflight_q == '0))
          | (in_valid & full & ~pop);
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Storage array. This array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // Output drivers. The FIFO head falls through to dout.
  always_comb begin
    dout     = mem_q[rd_ptr_q];
    count    = count_q;
    inflight = inflight_q;
    err      = err_q;
  end

endmodule

// File: tb/tb_pipe_drain_fifo.sv
// Self-checking bench for pipe_drain_fifo.
// It uses a directed vector table, corner-case sequences, and randomized traffic.
// The randomized traffic is compared against a queue-based reference model.
module tb_pipe_drain_fifo;

  localparam int DW    = 12;
  localparam int DEPTH = 16;
  localparam int LAT   = 7;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue;
  logic          issue_ok;
  logic          in_valid;
  logic [DW-1:0] din;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dout;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic          err;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state.
  int mq[$];
  int m_infl;
  bit m_err;

  // Emulated upstream pipeline.
  bit            sr_v [LAT];
  logic [DW-1:0] sr_d [LAT];

  typedef struct {
    int iss; int iv; int d; int rdy;
    int cnt; int infl; int ov; int dout; int ok; int err;
  } vec_t;
  vec_t tbl[12];

  pipe_drain_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .issue_ok(issue_ok),
    .in_valid(in_valid), .din(din), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .count(count), .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic model_clear();
    mq.delete();
    m_infl = 0;
    m_err  = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      sr_v[i] = 1'b0;
      sr_d[i] = '0;
    end
  endtask

  // Apply the rules from the behavioural description to one clock edge.
  task automatic model_step(input bit iss, input bit iv, input logic [DW-1:0] d, input bit rdy);
    bit ok, full, pop;
    ok   = (mq.size() + m_infl) < DEPTH;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && rdy;
    if ((iss && !ok) || (iv && m_infl == 0) || (iv && full && !pop)) m_err = 1'b1;
    if (pop) void'(mq.pop_front());
    if (iv && (!full || pop)) mq.push_back(int'(d));
    if (iss && !iv && m_infl < DEPTH) m_infl++;
    else if (iv && !iss && m_infl > 0) m_infl--;
  endtask

  task automatic drive_raw(input bit iss, input bit iv, input logic [DW-1:0] d, input bit rdy);
    issue = iss; in_valid = iv; din = d; out_ready = rdy;
    model_step(iss, iv, d, rdy);
    @(posedge clk); #1;
  endtask

  task automatic drive_pipe(input bit iss, input logic [DW-1:0] d, input bit rdy);
    bit            iv;
    logic [DW-1:0] od;
    iv = sr_v[LAT-1];
    od = sr_d[LAT-1];
    for (int i = LAT - 1; i > 0; i--) begin
      sr_v[i] = sr_v[i-1];
      sr_d[i] = sr_d[i-1];
    end
    sr_v[0] = iss;
    sr_d[0] = d;
    drive_raw(iss, iv, od, rdy);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, int'(count), mq.size());
    chk({tag, "_inflight"}, int'(inflight), m_infl);
    chk({tag, "_out_valid"}, int'(out_valid), int'(mq.size() != 0));
    chk({tag, "_issue_ok"}, int'(issue_ok), int'((mq.size() + m_infl) < DEPTH));
    chk({tag, "_err"}, int'(err), int'(m_err));
    if (mq.size() != 0) chk({tag, "_dout"}, int'(dout), mq[0]);
  endtask

  task automatic do_reset();
    issue = 0; in_valid = 0; din = '0; out_ready = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    int issued, exp_seq, cyc;
    bit iss, rdy;

    // Row format: issue, in_valid, din, ready -> count, inflight, out_valid, dout, issue_ok, err.
    tbl[0]  = '{1, 0, 0,     0, 0, 1, 0, 0,     1, 0};
    for (int i = 1; i <= 6; i++) tbl[i] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    tbl[7]  = '{0, 1, 'h0A5, 1, 1, 0, 1, 'h0A5, 1, 0};
    tbl[8]  = '{0, 0, 0,     1, 0, 0, 0, 0,     1, 0};
    tbl[9]  = '{1, 0, 0,     0, 0, 1, 0, 0,     1, 0};
    tbl[10] = '{1, 1, 'h123, 0, 1, 1, 1, 'h123, 1, 0};
    tbl[11] = '{0, 1, 'h456, 0, 2, 0, 1, 'h123, 1, 0};

    model_clear();
    issue = 0; in_valid = 0; din = '0; out_ready = 0;
    rst_n = 1'b0;
    #3;
    chk("rst_count", int'(count), 0);
    chk("rst_inflight", int'(inflight), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_issue_ok", int'(issue_ok), 1);
    chk("rst_err", int'(err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Test 1: single-op round trip and basic push/pop patterns.
    for (int i = 0; i < 12; i++) begin
      drive_raw(tbl[i].iss[0], tbl[i].iv[0], DW'(tbl[i].d), tbl[i].rdy[0]);
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
      chk($sformatf("tbl%0d_inflight", i), int'(inflight), tbl[i].infl);
      chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), tbl[i].ov);
      if (tbl[i].ov != 0) chk($sformatf("tbl%0d_dout", i), int'(dout), tbl[i].dout);
      chk($sformatf("tbl%0d_issue_ok", i), int'(issue_ok), tbl[i].ok);
      chk($sformatf("tbl%0d_err", i), int'(err), tbl[i].err);
    end

    // Test 2: the consumer is stalled, and upstream issues whenever a credit is free.
    do_reset();
    issued = 0;
    for (int c = 0; c < 40; c++) begin
      iss = ((mq.size() + m_infl) < DEPTH);
      drive_pipe(iss, DW'(issued), 1'b0);
      if (iss) issued++;
      check_model("fill");
    end
    chk("fill_issues", issued, 16);
    chk("fill_count", int'(count), 16);
    chk("fill_issue_ok", int'(issue_ok), 0);
    chk("fill_err", int'(err), 0);

    // Test 3: with the FIFO full, a push and a pop occur in the same cycle.
    drive_raw(1'b0, 1'b1, DW'('h0AA), 1'b1);
    chk("full_pp_count", int'(count), 16);
    chk("full_pp_head", int'(dout), 1);
    check_model("full_pp");
    for (int c = 0; c < 16; c++) begin
      drive_raw(1'b0, 1'b0, '0, 1'b1);
      check_model("full_drain");
    end

    // Test 4: stream 40 words while out_ready toggles between 1 and 0.
    do_reset();
    issued = 0; exp_seq = 0; cyc = 0;
    while (exp_seq < 40 && cyc < 500) begin
      rdy = (cyc % 2) == 0;
      iss = (issued < 40) && ((mq.size() + m_infl) < DEPTH);
      if (out_valid && rdy) begin
        chk("stream_order", int'(dout), exp_seq);
        exp_seq++;
      end
      drive_pipe(iss, DW'(issued), rdy);
      if (iss) issued++;
      check_model("stream");
      cyc++;
    end
    chk("stream_done", exp_seq, 40);
    chk("stream_err", int'(err), 0);

    // Test 5: protocol errors. First, a word arrives with no op in flight.
    drive_raw(1'b0, 1'b1, DW'(5), 1'b0);
    chk("err_noinflight", int'(err), 1);
    for (int c = 0; c < 3; c++) drive_raw(1'b0, 1'b0, '0, 1'b1);
    chk("err_sticky", int'(err), 1);
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive_raw(1'b1, 1'b0, '0, 1'b0);
      check_model("over");
    end
    chk("over_ok_low", int'(issue_ok), 0);
    chk("over_err_before", int'(err), 0);
    drive_raw(1'b1, 1'b0, '0, 1'b0);
    chk("over_err", int'(err), 1);
    check_model("over_after");

    // Test 6: an asynchronous reset while data is stored and ops are in flight.
    do_reset();
    issued = 0; cyc = 0;
    while (!(mq.size() == 5 && m_infl == 3) && cyc < 50) begin
      iss = (issued < 8);
      drive_pipe(iss, DW'(issued + 'h100), 1'b0);
      if (iss) issued++;
      cyc++;
    end
    chk("mid_count_pre", int'(count), 5);
    chk("mid_inflight_pre", int'(inflight), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_inflight", int'(inflight), 0);
    chk("arst_issue_ok", int'(issue_ok), 1);
    issue = 0; in_valid = 0; out_ready = 0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized legal traffic, checked against the reference model.
    issued = 0;
    for (int c = 0; c < 400; c++) begin
      if (((c / 40) % 2) == 0) rdy = ($urandom % 4) == 0;
      else rdy = ($urandom % 4) != 0;
      iss = ((mq.size() + m_infl) < DEPTH) && (($urandom % 2) == 1);
      drive_pipe(iss, DW'($urandom), rdy);
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
